// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared state encoding and sizing constants for the 2-D IDCT controller
package jpeg_pkg;
    localparam int IDCT_LANE_W = 32;
    localparam int BLK_SIZE    = 64;
    localparam int PIX_W       = 8;
    typedef enum logic [1:0] {LOAD, ROW, COL, OUT} state_t;
endpackage

// File: rtl/jpeg_pix_clamp.sv
// jpeg_pix_clamp: +128 level shift and saturation of a signed lane to an unsigned pixel
module jpeg_pix_clamp
    import jpeg_pkg::*;
(
    input  logic signed [IDCT_LANE_W-1:0] i_val,
    output logic [PIX_W-1:0]              o_pix
);
    logic signed [IDCT_LANE_W:0] w_sum;
    // one extra bit so the level shift cannot wrap near the top of the range
    assign w_sum = {i_val[IDCT_LANE_W-1], i_val} + 33'sd128;
    assign o_pix = w_sum[IDCT_LANE_W] ? '0 : (w_sum > 33'sd255) ? '1 : w_sum[PIX_W-1:0];
endmodule

// File: rtl/jpeg_idct_2d_ctrl.sv
// jpeg_idct_2d_ctrl: row/column sequencing of an external 1-D IDCT over one 8x8 block
module jpeg_idct_2d_ctrl
    import jpeg_pkg::*;
#(
    parameter int COEF_W = 16
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coef_valid,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic                       coef_ready,
    output logic [8*IDCT_LANE_W-1:0]   idct_in,
    input  logic [8*IDCT_LANE_W-1:0]   idct_out,
    output logic                       pix_valid,
    output logic [PIX_W-1:0]           pix_data,
    input  logic                       pix_ready,
    output logic                       busy,
    output logic                       block_done
);
    state_t                        r_state, w_next;
    logic [5:0]                    r_idx;
    logic                          r_gap;
    logic signed [IDCT_LANE_W-1:0] r_buf [BLK_SIZE];
    logic [5:0]                    w_addr [8];
    logic                          w_coef_acc, w_pix_acc, w_last, w_pass;
    logic [PIX_W-1:0]              w_clamp;

    assign w_last     = r_idx == 6'(BLK_SIZE - 1);
    assign w_pass     = r_state == ROW || r_state == COL;
    assign w_coef_acc = coef_valid && r_state == LOAD && !r_gap;
    assign w_pix_acc  = pix_ready && r_state == OUT;
    assign block_done = w_pix_acc && w_last;
    assign pix_data   = pix_valid ? w_clamp : '0;

    always_comb begin
        w_next     = r_state;
        coef_ready = r_state == LOAD && !r_gap;
        pix_valid  = r_state == OUT;
        busy       = r_state != LOAD;
        case (r_state)
            LOAD:    w_next = (w_coef_acc && w_last) ? ROW : LOAD;
            ROW:     w_next = (r_idx[2:0] == 3'd7) ? COL : ROW;
            COL:     w_next = (r_idx[2:0] == 3'd7) ? OUT : COL;
            default: w_next = block_done ? LOAD : OUT;
        endcase
    end

    // r_gap holds coef_ready low for the single cycle after the last pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            r_idx   <= '0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gap   <= block_done;
            r_idx   <= (w_coef_acc || w_pix_acc) ? r_idx + 6'd1
                     : w_pass ? {3'd0, r_idx[2:0] + 3'd1} : r_idx;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign w_addr[k] = (r_state == ROW) ? {r_idx[2:0], 3'(k)} : {3'(k), r_idx[2:0]};
        assign idct_in[IDCT_LANE_W*k +: IDCT_LANE_W] = w_pass ? r_buf[w_addr[k]] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_coef_acc)
            r_buf[r_idx] <= IDCT_LANE_W'(coef_data);
        else if (!rst && w_pass)
            for (int i = 0; i < 8; i++)
                r_buf[w_addr[i]] <= idct_out[IDCT_LANE_W*i +: IDCT_LANE_W];
    end

    jpeg_pix_clamp u_clamp (
        .i_val (r_buf[r_idx]),
        .o_pix (w_clamp)
    );
endmodule

// File: tb/tb_jpeg_idct_2d_ctrl.sv
// tb_jpeg_idct_2d_ctrl: directed checks of the 2-D IDCT controller with a floating-point 1-D IDCT stub
module tb_jpeg_idct_2d_ctrl;
    logic               clk = 1'b0;
    logic               rst, coef_valid, coef_ready, pix_valid, pix_ready, busy, block_done;
    logic signed [15:0] coef_data;
    logic [255:0]       idct_in, idct_out;
    logic [7:0]         pix_data;
    int                 cyc = 0, t_last = 0, n_chk = 0, n_pass = 0;

    jpeg_idct_2d_ctrl #(.COEF_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .idct_in    (idct_in),
        .idct_out   (idct_out),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .block_done (block_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // orthonormal 8-point IDCT, rounded to nearest integer
    function automatic logic [255:0] idct8(input logic [255:0] v);
        logic [255:0] r;
        real s, cu;
        int a;
        r = '0;
        for (int x = 0; x < 8; x++) begin
            s = 0.0;
            for (int u = 0; u < 8; u++) begin
                a  = v[32*u +: 32];
                cu = (u == 0) ? 0.5 / $sqrt(2.0) : 0.5;
                s  = s + cu * real'(a) * $cos(real'((2*x+1)*u) * 3.14159265358979 / 16.0);
            end
            r[32*x +: 32] = int'(s);
        end
        return r;
    endfunction

    always_comb idct_out = idct8(idct_in);

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic load(input int dc, input int n0, input logic keep);
        int n, guard;
        n = n0;
        guard = 0;
        while (n < 64) begin
            coef_valid = 1'b1;
            coef_data  = (n == 0) ? 16'(dc) : 16'sd0;
            #1;
            if (coef_ready) begin
                t_last = cyc;
                n++;
            end
            @(negedge clk);
            if (++guard > 500) begin
                chk("load_timeout", n, 64);
                break;
            end
        end
        coef_valid = keep;
        coef_data  = '0;
    endtask

    task automatic drain(input string nm, input int exp, input logic rnd);
        int n, bad, dones, stall_bad, extra, guard, first;
        logic stalled;
        logic [7:0] held;
        n = 0; bad = 0; dones = 0; stall_bad = 0; extra = 0; guard = 0; first = -1;
        stalled = 1'b0;
        held = '0;
        while (n < 64) begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pix_valid) begin
                if (first < 0) first = cyc;
                if (pix_data != 8'(exp)) bad++;
                if (stalled && pix_data != held) stall_bad++;
                stalled = !pix_ready;
                held = pix_data;
                if (pix_ready) n++;
            end
            if (block_done) dones++;
            @(negedge clk);
            if (++guard > 2000) begin
                chk({nm, "_timeout"}, n, 64);
                break;
            end
        end
        repeat (3) begin
            pix_ready = 1'b1;
            #1;
            if (pix_valid) extra++;
            if (block_done) dones++;
            @(negedge clk);
        end
        pix_ready = 1'b0;
        chk({nm, "_latency"}, first - t_last, 17);
        chk({nm, "_count"}, n, 64);
        chk({nm, "_value"}, bad, 0);
        chk({nm, "_stall"}, stall_bad, 0);
        chk({nm, "_done"}, dones, 1);
        chk({nm, "_extra"}, extra, 0);
    endtask

    initial begin
        int low, pa, bad, got;
        rst = 1'b1; coef_valid = 1'b0; coef_data = '0; pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_coef_ready", int'(coef_ready), 1);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_block_done", int'(block_done), 0);
        chk("rst_idct_in_nz", int'(idct_in != '0), 0);
        rst = 1'b0;
        @(negedge clk);

        load(0, 0, 1'b0);
        drain("zero", 128, 1'b0);

        load(64, 0, 1'b0);
        #1;
        chk("row0_lane0", int'(idct_in[31:0]), 64);
        chk("row0_lane1", int'(idct_in[63:32]), 0);
        chk("row_coef_ready", int'(coef_ready), 0);
        chk("row_busy", int'(busy), 1);
        repeat (8) @(negedge clk);
        #1;
        chk("col0_lane0", int'(idct_in[31:0]), 23);
        chk("col0_lane1", int'(idct_in[63:32]), 0);
        @(negedge clk);
        #1;
        chk("col1_lane0", int'(idct_in[31:0]), 23);
        chk("col1_lane7", int'(idct_in[255:224]), 0);
        @(negedge clk);
        drain("dc64", 136, 1'b0);

        load(1016, 0, 1'b0);
        drain("sat_hi", 255, 1'b0);
        load(-1024, 0, 1'b0);
        drain("sat_lo", 0, 1'b0);

        load(64, 0, 1'b0);
        drain("stall", 136, 1'b1);

        load(64, 0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_coef_ready", int'(coef_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pix_valid", int'(pix_valid), 0);
        chk("midrst_idct_nz", int'(idct_in != '0), 0);
        rst = 1'b0;
        @(negedge clk);
        load(0, 0, 1'b0);
        drain("after_rst", 128, 1'b0);

        load(0, 0, 1'b1);
        low = 0; pa = 0; bad = 0; got = 0;
        for (int i = 0; i < 300; i++) begin
            coef_data = 16'sd64;
            pix_ready = 1'b1;
            #1;
            if (coef_ready) begin
                t_last = cyc;
                got = 1;
                @(negedge clk);
                break;
            end
            low++;
            if (pix_valid) begin
                pa++;
                if (pix_data != 8'd128) bad++;
            end
            @(negedge clk);
        end
        chk("b2b_gap", low, 81);
        chk("b2b_reopen", got, 1);
        chk("b2b_a_count", pa, 64);
        chk("b2b_a_value", bad, 0);
        load(64, 1, 1'b0);
        drain("b2b_b", 136, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jpeg_idct_2d_ctrl.md
JPEG_IDCT_2D_CTRL -- requirements
Module: jpeg_idct_2d_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter COEF_W, default 16, SHALL set the signed width of each input coefficient.
REQ-003 clk  in  1  rising-edge clock, sole clock domain.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 coef_valid  in  1  input coefficient valid.
REQ-006 coef_data  in  COEF_W  signed dequantized coefficient, natural row-major order (index = 8*row+col).
REQ-007 coef_ready  out  1  block can accept a coefficient.
REQ-008 idct_in  out  256  eight signed 32-bit operands to the shared 1-D IDCT; lane k is bits [32k+31:32k].
REQ-009 idct_out  in  256  eight signed 32-bit results from the 1-D IDCT, same lane mapping, combinational.
REQ-010 pix_valid  out  1  output pixel valid.
REQ-011 pix_data  out  8  unsigned level-shifted, saturated pixel.
REQ-012 pix_ready  in  1  downstream accepts pixel.
REQ-013 busy  out  1  high in every state except LOAD.
REQ-014 block_done  out  1  one-cycle pulse when the 64th pixel is accepted.

Function
REQ-015 The block SHALL hold one 64 x 32-bit signed working buffer and a 6-bit index counter.
REQ-016 The FSM SHALL have states LOAD, ROW, COL, OUT; LOAD is entered at reset.
REQ-017 LOAD: coef_ready=1; each cycle with coef_valid&coef_ready SHALL store the sign-extended coef_data at buf[idx] and increment idx. Acceptance of idx=63 SHALL move to ROW with idx=0.
REQ-018 ROW: each of 8 cycles r=0..7 SHALL drive idct_in lane k = buf[8r+k] and write idct_out lane k back to buf[8r+k] in the same cycle. After r=7 the FSM SHALL move to COL.
REQ-019 COL: each of 8 cycles c=0..7 SHALL drive lane k = buf[8k+c] and write lane k back to buf[8k+c]. After c=7 the FSM SHALL move to OUT with idx=0.
REQ-020 In states other than ROW and COL, idct_in SHALL be driven to 0.
REQ-021 OUT: pix_valid=1; pix_data = clamp(buf[idx]+128, 0, 255). idx SHALL advance only on pix_valid&pix_ready. pix_data SHALL be stable while pix_valid=1 and pix_ready=0.
REQ-022 Acceptance of idx=63 in OUT SHALL pulse block_done and return to LOAD with idx=0. coef_ready SHALL first rise on the following cycle; no overlap of blocks.
REQ-023 coef_valid outside LOAD SHALL be ignored (coef_ready=0). pix_ready outside OUT SHALL be ignored.
REQ-024 Latency from the last coefficient accepted to the first pix_valid SHALL be exactly 17 cycles.
REQ-025 With no backpressure, throughput SHALL be one block per 145 cycles (64 + 8 + 8 + 64 + 1).
REQ-026 Clamp arithmetic SHALL use full 32-bit signed compare; the value SHALL saturate at 0 and 255, with no wrap.

Reset
REQ-027 On rst, the FSM SHALL go to LOAD, idx SHALL be 0, and outputs SHALL be: coef_ready=1, pix_valid=0, pix_data=0, busy=0, block_done=0, idct_in=0.
REQ-028 Reset mid-block SHALL discard all buffered data. Buffer contents SHALL not be required to clear, since LOAD overwrites all 64 entries before use.
REQ-029 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-030 Package jpeg_pkg SHALL hold: the state enum (LOAD/ROW/COL/OUT), IDCT_LANE_W=32, BLK_SIZE=64, and PIX_W=8.
REQ-031 The 1-D IDCT SHALL remain external, connected only through idct_in/idct_out, so that it can be shared or replaced.
REQ-032 One sub-module, jpeg_pix_clamp (32-bit signed in, +128 level shift, 8-bit saturate out), SHALL be instantiated.

Verification
REQ-033 All 64 coefficients = 0 -> 64 pixels of 128, then a block_done pulse.
REQ-034 coef[0]=64, others 0 -> row pass buf[0..7]=23; column pass all entries 8; 64 pixels of 136.
REQ-035 coef[0]=1016 -> 64 pixels of 255 (saturate high); coef[0]=-1024 -> 64 pixels of 0 (saturate low).
REQ-036 pix_ready toggled at random (~50%) on the REQ-034 block -> exactly 64 pixels of 136, each held stable while stalled, and block_done exactly once.
REQ-037 rst asserted during COL of block A, then block B (REQ-033) loaded -> no pixel from A appears and B outputs 64 pixels of 128.
REQ-038 Two back-to-back blocks with coef_valid held high -> coef_ready=0 for 81 cycles between them, the 17-cycle latency is met, and no coefficient is lost.
